// File: rtl/fpu_pkg.sv
// Shared FPU definitions: the one-hot class encoding and the single-precision
// classifier that every FPU block uses.
package fpu_pkg;

   localparam int FCLASS_W    = 32;
   localparam int FCLASS_NINF = 0;
   localparam int FCLASS_NNRM = 1;
   localparam int FCLASS_NSUB = 2;
   localparam int FCLASS_NZER = 3;
   localparam int FCLASS_PZER = 4;
   localparam int FCLASS_PSUB = 5;
   localparam int FCLASS_PNRM = 6;
   localparam int FCLASS_PINF = 7;
   localparam int FCLASS_SNAN = 8;
   localparam int FCLASS_QNAN = 9;

   typedef enum logic [9:0] {
      FC_NINF = 10'h001,
      FC_NNRM = 10'h002,
      FC_NSUB = 10'h004,
      FC_NZER = 10'h008,
      FC_PZER = 10'h010,
      FC_PSUB = 10'h020,
      FC_PNRM = 10'h040,
      FC_PINF = 10'h080,
      FC_SNAN = 10'h100,
      FC_QNAN = 10'h200
   } fclass_e;

   // NaN classes ignore the sign; everything else splits on it.
   function automatic logic [FCLASS_W-1:0] fclassify(input logic [31:0] op);
      logic                sgn;
      logic [7:0]          e;
      logic [22:0]         m;
      logic [FCLASS_W-1:0] c;
      sgn = op[31];
      e   = op[30:23];
      m   = op[22:0];
      c   = '0;
      if (e == 8'hFF) begin
         if (m == '0)   c[sgn ? FCLASS_NINF : FCLASS_PINF] = 1'b1;
         else if (m[22]) c[FCLASS_QNAN] = 1'b1;
         else           c[FCLASS_SNAN] = 1'b1;
      end else if (e == 8'h00) begin
         if (m == '0) c[sgn ? FCLASS_NZER : FCLASS_PZER] = 1'b1;
         else         c[sgn ? FCLASS_NSUB : FCLASS_PSUB] = 1'b1;
      end else begin
         c[sgn ? FCLASS_NNRM : FCLASS_PNRM] = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/fclass_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module fclass_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx
);

   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/fclass_arbiter.sv
// Round-robin front end sharing one FP classifier across NUM_REQ requesters,
// with an issue register (S1) and a response register (S2).
module fclass_arbiter
   import fpu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][31:0]        req_operand,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [FCLASS_W-1:0]             rsp_class,
   output logic [ID_W-1:0]                 rsp_id,
   output logic [TAG_W-1:0]                rsp_tag,
   output logic                            busy
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gidx;
   logic [ID_W-1:0]    rr_ptr;
   logic               s1_valid;
   logic [31:0]        s1_operand;
   logic [TAG_W-1:0]   s1_tag;
   logic [ID_W-1:0]    s1_id;
   logic               s1_load;
   logic               s2_load;
   logic               hs;

   fclass_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx)
   );

   // Grant only ever covers valid requesters, so any ready bit is a handshake.
   assign s2_load   = s1_valid & (~rsp_valid | rsp_ready);
   assign s1_load   = ~s1_valid | s2_load;
   assign req_ready = grant & {NUM_REQ{s1_load}};
   assign hs        = |req_ready;
   assign busy      = s1_valid | rsp_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         s1_valid   <= 1'b0;
         s1_operand <= '0;
         s1_tag     <= '0;
         s1_id      <= '0;
         rsp_valid  <= 1'b0;
         rsp_class  <= '0;
         rsp_id     <= '0;
         rsp_tag    <= '0;
      end else begin
         if (hs) begin
            s1_operand <= req_operand[gidx];
            s1_tag     <= req_tag[gidx];
            s1_id      <= gidx;
            rr_ptr     <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
         end
         s1_valid <= hs | (s1_valid & ~s2_load);
         if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_class <= fclassify(s1_operand);
            rsp_tag   <= s1_tag;
            rsp_id    <= s1_id;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
